ip_clk_wiz_gen: RTL and testbench

Clock-generation block that sits between the board oscillator input and the fabric clock domains. It takes a 100 MHz reference and produces four synchronous clocks: 100 MHz, 100 MHz inverted (180°), 50 MHz and 25 MHz. All outputs are held low during reset and start cleanly, with no glitches, after reset release. It also reports a `locked` status.

---
 rtl/ip_clk_wiz_gen.sv | 97 +++++++++
 tb/tb_ip_clk_wiz_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ip_clk_wiz_gen.sv
// ip_clk_wiz_gen: derives gated 100 MHz (0/180 deg), 50 MHz and 25 MHz clocks from a 100 MHz reference.
// Latency: locked 1 ref edge after reset release (LOCK_CYCLES+1 with the lock delay), clk_100m at edge 2.
// Backpressure: none; free-running clock outputs, no flow control.
//
// Ports:
//   clk              100 MHz reference clock
//   sys_rst          asynchronous active-high reset; forces every output low immediately
//   clk_100m         clk gated by an enable that changes only while clk is low
//   clk_100m_180deg  ~clk gated by an enable that changes only while ~clk is low
//   clk_50m/clk_25m  registered divide-by-2 / divide-by-4 outputs, 50 % duty
//   locked           high once the outputs are running
//
// Optional feature: define CLK_WIZ_LOCK_DELAY_EN to hold the outputs off for
// LOCK_CYCLES reference edges after reset release. Without it the outputs
// start on the first rising edge after release.

`timescale 1ns/1ps

module ip_clk_wiz_gen #(
   parameter int IN_PERIOD_NS = 10,
   parameter int LOCK_CYCLES  = 16
) (
   input  logic clk,
   input  logic sys_rst,
   output logic clk_100m,
   output logic clk_100m_180deg,
   output logic clk_50m,
   output logic clk_25m,
   output logic locked
);

   // Elaboration-time sanity check on the parameters.
   if (IN_PERIOD_NS < 1 || LOCK_CYCLES < 2 || LOCK_CYCLES > 1023) begin : g_param_err
      $error("ip_clk_wiz_gen: IN_PERIOD_NS must be >= 1 and LOCK_CYCLES in 2..1023");
   end

   // The run flag is captured on the rising edge of clk, so the register
   // holding it is the rising-edge enable (run_p) itself.
   logic       run_p;
   logic       run_n;
   logic [1:0] div;

`ifdef CLK_WIZ_LOCK_DELAY_EN
   localparam logic [9:0] LOCK_LAST = 10'(LOCK_CYCLES);

   logic [9:0] lock_cnt;

   // Count reference edges after release; run sets on the edge after the
   // count reaches LOCK_CYCLES, and the counter then holds.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         lock_cnt <= '0;
         run_p    <= 1'b0;
      end else if (lock_cnt != LOCK_LAST) begin
         lock_cnt <= lock_cnt + 10'd1;
      end else begin
         run_p    <= 1'b1;
      end
   end
`else
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         run_p <= 1'b0;
      end else begin
         run_p <= 1'b1;
      end
   end
`endif

   // Enable for clk_100m is retimed to the falling edge so it only changes
   // while clk is low; the AND gate therefore never emits a runt pulse.
   always_ff @(negedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         run_n <= 1'b0;
      end else begin
         run_n <= run_p;
      end
   end

   // Divider advances on the same rising edges that clk_100m carries, so the
   // divided clocks rise aligned with clk_100m.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         div <= 2'd0;
      end else if (run_p) begin
         div <= div + 2'd1;
      end
   end

   // run_p changes on the rising edge of clk, i.e. while ~clk is low.
   assign clk_100m        = clk & run_n;
   assign clk_100m_180deg = ~clk & run_p;
   assign clk_50m         = div[0];
   assign clk_25m         = div[1];
   assign locked          = run_p;

endmodule

// File: tb/tb_ip_clk_wiz_gen.sv
`timescale 1ns/1ps

module tb_ip_clk_wiz_gen;

`ifdef CLK_WIZ_LOCK_DELAY_EN
   localparam int LD = 16;
`else
   localparam int LD = 0;
`endif

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   logic clk_100m, clk_100m_180deg, clk_50m, clk_25m, locked;

   int n_checks = 0;
   int n_fail   = 0;

   ip_clk_wiz_gen #(
      .IN_PERIOD_NS (10),
      .LOCK_CYCLES  (16)
   ) dut (
      .clk             (clk),
      .sys_rst         (sys_rst),
      .clk_100m        (clk_100m),
      .clk_100m_180deg (clk_100m_180deg),
      .clk_50m         (clk_50m),
      .clk_25m         (clk_25m),
      .locked          (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: k = rising edges of clk seen since reset release.
   // Running starts at edge LD+1; the gated 100 MHz clock and the divider
   // start one edge later, and the divided clocks are a plain edge count.
   task automatic check_outputs(input string tag, input int k, input logic hi_phase, input logic in_rst);
      logic running, gated_on;
      int   d;
      running  = !in_rst && (k >= LD + 1);
      gated_on = !in_rst && (k >= LD + 2);
      d        = running ? ((k - LD - 1) % 4) : 0;
      check({tag, ":clk_100m"},        32'(clk_100m),        32'(hi_phase && gated_on));
      check({tag, ":clk_100m_180deg"}, 32'(clk_100m_180deg), 32'(!hi_phase && running));
      check({tag, ":clk_50m"},         32'(clk_50m),         32'(d % 2));
      check({tag, ":clk_25m"},         32'(clk_25m),         32'(d / 2));
      check({tag, ":locked"},          32'(locked),          32'(running));
   endtask

   // Pulse-width monitor on every clock output: any high pulse that ends
   // outside reset must be at least half a reference period wide.
   logic [3:0] mon;
   assign mon = {clk_100m, clk_100m_180deg, clk_50m, clk_25m};

   for (genvar g = 0; g < 4; g++) begin : g_pw
      time t_rise = 0;
      always @(posedge mon[g]) t_rise = $time;
      always @(negedge mon[g]) begin
         if (!sys_rst) check("pulse_width", 32'(($time - t_rise) >= 5), 32'd1);
      end
   end

   // Phase relation: 180 deg output is the complement of clk_100m once both run.
   task automatic check_phase(input int k);
      if (k >= LD + 2) check("phase_180", 32'(clk_100m_180deg), 32'(!clk_100m));
   endtask

   initial begin
      int k;
      int n_run;

      // Initial reset: 20 ns with clock running, everything low.
      for (int i = 0; i < 4; i++) begin
         #2;
         check_outputs("reset_hold", 0, clk, 1'b1);
         #3;
      end

      for (int trial = 0; trial < 6; trial++) begin
         // Release either just after a rising or just after a falling edge.
         if ($urandom_range(0, 1) == 0) @(posedge clk);
         else                           @(negedge clk);
         #1;
         sys_rst = 1'b0;
         #1;
         check_outputs("release", 0, clk, 1'b0);

         k     = 0;
         n_run = LD + 4 + int'($urandom_range(0, 16));
         for (int c = 0; c < n_run; c++) begin
            @(posedge clk);
            k++;
            #2;
            check_outputs("run_hi", k, 1'b1, 1'b0);
            check_phase(k);
            @(negedge clk);
            #2;
            check_outputs("run_lo", k, 1'b0, 1'b0);
            check_phase(k);
         end
         // Even trials: carry on until clk_25m is high so reset hits its high phase.
         if (trial % 2 == 0) begin
            for (int c = 0; c < 4 && (((k - LD - 1) % 4) / 2) == 0; c++) begin
               @(posedge clk);
               k++;
               #2;
               check_outputs("run_hi", k, 1'b1, 1'b0);
            end
            check("c25_high_before_rst", 32'(clk_25m), 32'd1);
         end

         // Asynchronous reset at a random point inside the cycle.
         @(posedge clk);
         #($urandom_range(1, 8));
         sys_rst = 1'b1;
         #1;
         check_outputs("async_rst", 0, clk, 1'b1);

         // Hold reset for a random number of cycles, outputs stay low.
         for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
            @(posedge clk);
            #2;
            check_outputs("rst_hold", 0, 1'b1, 1'b1);
            @(negedge clk);
            #2;
            check_outputs("rst_hold", 0, 1'b0, 1'b1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
